commit_marker_injector: RTL and testbench

Inserts control-flow marker entries into the scoreboard-entry stream feeding the commit-side call/return parser. Each call (JAL/JALR with rd=x1) or return (JALR rs1=x1, rd=x0) is followed by a marker NOP: ALU ADD x0,x0 with use_imm set and result 2 for a call, 1 for a return. The block sits between issue-side entry production and the parser and is a one-deep registered stage with valid/ack handshakes.

---
 rtl/cfi_marker_pkg.sv | 86 ++++++++
 rtl/commit_marker_classifier.sv | 22 ++
 rtl/commit_marker_injector.sv | 150 +++++++++++++++
 tb/tb_commit_marker_injector.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfi_marker_pkg.sv
// Shared types for the commit-side call/return marker path: scoreboard entry layout,
// marker kinds, marker result encodings and the marker-entry constructor.
package cfi_marker_pkg;

    localparam int XLEN          = 32;
    localparam int TRANS_ID_BITS = 3;

    typedef enum logic [2:0] {
        FU_NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef enum logic [3:0] {
        ADD,
        SUB,
        ANDL,
        ORL,
        XORL,
        SLTS,
        JAL,
        JALR,
        EQ,
        NE
    } fu_op_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] cause;
    } exception_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] cf_type;
    } bp_t;

    typedef struct packed {
        logic [XLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        fu_op_e                   op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [XLEN-1:0]          result;
        logic                     valid;
        logic                     use_imm;
        logic                     use_zimm;
        logic                     use_pc;
        exception_t               ex;
        bp_t                      bp;
        logic                     is_compressed;
    } scoreboard_entry_t;

    typedef enum logic [1:0] {
        NONE,
        CALL,
        RET
    } marker_kind_e;

    localparam logic [XLEN-1:0] MARKER_CALL = 32'd2;
    localparam logic [XLEN-1:0] MARKER_RET  = 32'd1;

    // Marker is an architectural NOP (ADD x0,x0,imm); only result carries the kind.
    function automatic scoreboard_entry_t make_marker(
        input marker_kind_e             kind,
        input logic [XLEN-1:0]          pc,
        input logic [TRANS_ID_BITS-1:0] trans_id
    );
        scoreboard_entry_t m;
        m          = '0;
        m.pc       = pc;
        m.trans_id = trans_id;
        m.fu       = ALU;
        m.op       = ADD;
        m.use_imm  = 1'b1;
        m.valid    = 1'b1;
        m.result   = (kind == CALL) ? MARKER_CALL : MARKER_RET;
        return m;
    endfunction

endpackage

// File: rtl/commit_marker_classifier.sv
// Combinational call/return classifier for a scoreboard entry; also reused by
// the commit-side parser so both ends agree on what counts as a call or return.
module commit_marker_classifier
    import cfi_marker_pkg::*;
(
    input  scoreboard_entry_t entry_i,
    output marker_kind_e      kind_o
);

    // Call wins over return, so JALR x1,x1 is treated as a call.
    always_comb begin
        kind_o = NONE;
        if (entry_i.valid && !entry_i.ex.valid && entry_i.fu == CTRL_FLOW) begin
            if ((entry_i.op == JAL || entry_i.op == JALR) && entry_i.rd == 5'd1) begin
                kind_o = CALL;
            end else if (entry_i.op == JALR && entry_i.rs1 == 5'd1 && entry_i.rd == 5'd0) begin
                kind_o = RET;
            end
        end
    end

endmodule

// File: rtl/commit_marker_injector.sv
// One-deep registered stage that follows every call/return entry with a marker NOP.
// Optional call-depth tracking with underflow pulse is enabled by CALL_DEPTH_TRACK_EN.
module commit_marker_injector
    import cfi_marker_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 csr_en_i,
    input  logic                 valid_i,
    input  scoreboard_entry_t    instr_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output scoreboard_entry_t    instr_o,
    input  logic                 ack_i,
    output logic [CNT_WIDTH-1:0] call_cnt_o,
    output logic [CNT_WIDTH-1:0] ret_cnt_o,
    output logic                 underflow_o
);

    scoreboard_entry_t          outEntry_q, outEntry_d;
    logic                       outValid_q, outValid_d;
    marker_kind_e               outKind_q, outKind_d;
    marker_kind_e               pendKind_q, pendKind_d;
    logic [XLEN-1:0]            pendPc_q, pendPc_d;
    logic [TRANS_ID_BITS-1:0]   pendTid_q, pendTid_d;
    logic [CNT_WIDTH-1:0]       callCnt_q, callCnt_d;
    logic [CNT_WIDTH-1:0]       retCnt_q, retCnt_d;

    marker_kind_e inKind;
    logic         inXfer;
    logic         outAck;

    commit_marker_classifier u_classifier (
        .entry_i (instr_i),
        .kind_o  (inKind)
    );

    assign ready_o = (!outValid_q || ack_i) && (pendKind_q == NONE) && !flush_i;
    assign inXfer  = valid_i && ready_o;
    assign outAck  = outValid_q && ack_i && !flush_i;

    // outKind_q tags what is currently presented so only acked markers are counted.
    always_comb begin
        outEntry_d = outEntry_q;
        outValid_d = outValid_q;
        outKind_d  = outKind_q;
        pendKind_d = pendKind_q;
        pendPc_d   = pendPc_q;
        pendTid_d  = pendTid_q;
        callCnt_d  = callCnt_q;
        retCnt_d   = retCnt_q;

        if (flush_i) begin
            outValid_d = 1'b0;
            outKind_d  = NONE;
            pendKind_d = NONE;
        end else begin
            if (outAck && outKind_q == CALL && callCnt_q != '1) begin
                callCnt_d = callCnt_q + 1'b1;
            end
            if (outAck && outKind_q == RET && retCnt_q != '1) begin
                retCnt_d = retCnt_q + 1'b1;
            end

            if (outAck && pendKind_q != NONE) begin
                outEntry_d = make_marker(pendKind_q, pendPc_q, pendTid_q);
                outValid_d = 1'b1;
                outKind_d  = pendKind_q;
                pendKind_d = NONE;
            end else if (inXfer) begin
                outEntry_d = instr_i;
                outValid_d = 1'b1;
                outKind_d  = NONE;
                if (csr_en_i && inKind != NONE) begin
                    pendKind_d = inKind;
                    pendPc_d   = instr_i.pc;
                    pendTid_d  = instr_i.trans_id;
                end
            end else if (outAck) begin
                outValid_d = 1'b0;
                outKind_d  = NONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            outEntry_q <= '0;
            outValid_q <= 1'b0;
            outKind_q  <= NONE;
            pendKind_q <= NONE;
            pendPc_q   <= '0;
            pendTid_q  <= '0;
            callCnt_q  <= '0;
            retCnt_q   <= '0;
        end else begin
            outEntry_q <= outEntry_d;
            outValid_q <= outValid_d;
            outKind_q  <= outKind_d;
            pendKind_q <= pendKind_d;
            pendPc_q   <= pendPc_d;
            pendTid_q  <= pendTid_d;
            callCnt_q  <= callCnt_d;
            retCnt_q   <= retCnt_d;
        end
    end

    assign valid_o    = outValid_q;
    assign instr_o    = outEntry_q;
    assign call_cnt_o = callCnt_q;
    assign ret_cnt_o  = retCnt_q;

`ifdef CALL_DEPTH_TRACK_EN
    logic [CNT_WIDTH-1:0] depth_q, depth_d;
    logic                 underflow_q, underflow_d;

    // A return at depth 0 leaves depth pinned at 0 and flags underflow instead.
    always_comb begin
        depth_d     = depth_q;
        underflow_d = 1'b0;
        if (outAck && outKind_q == CALL && depth_q != '1) begin
            depth_d = depth_q + 1'b1;
        end else if (outAck && outKind_q == RET) begin
            if (depth_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                depth_d = depth_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            depth_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            underflow_q <= underflow_d;
        end
    end

    assign underflow_o = underflow_q;
`else
    assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_commit_marker_injector.sv
// Scoreboard bench for commit_marker_injector: directed entries push expected outputs,
// a negedge monitor pops and compares every accepted output.
module tb_commit_marker_injector;
    import cfi_marker_pkg::*;

    localparam int CW = 16;

    logic              clk_i = 1'b0;
    logic              rst_n;
    logic              flush_i;
    logic              csr_en_i;
    logic              valid_i;
    scoreboard_entry_t instr_i;
    logic              ready_o;
    logic              valid_o;
    scoreboard_entry_t instr_o;
    logic              ack_i;
    logic [CW-1:0]     call_cnt_o;
    logic [CW-1:0]     ret_cnt_o;
    logic              underflow_o;

    int compared   = 0;
    int mismatched = 0;
    int pulseCnt   = 0;
    scoreboard_entry_t expQ[$];

    commit_marker_injector #(.CNT_WIDTH(CW)) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .csr_en_i    (csr_en_i),
        .valid_i     (valid_i),
        .instr_i     (instr_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .instr_o     (instr_o),
        .ack_i       (ack_i),
        .call_cnt_o  (call_cnt_o),
        .ret_cnt_o   (ret_cnt_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic scoreboard_entry_t mkEntry(input fu_t fu, input fu_op_e op,
                                                  input logic [4:0] rs1, input logic [4:0] rd,
                                                  input logic [31:0] pc, input logic [2:0] tid);
        scoreboard_entry_t e;
        e          = '0;
        e.fu       = fu;
        e.op       = op;
        e.rs1      = rs1;
        e.rs2      = 5'd3;
        e.rd       = rd;
        e.pc       = pc;
        e.trans_id = tid;
        e.result   = 32'hDEAD_0000 | pc;
        e.use_pc   = 1'b1;
        e.valid    = 1'b1;
        return e;
    endfunction

    function automatic scoreboard_entry_t expMarker(input logic [31:0] pc, input logic [2:0] tid,
                                                    input logic [31:0] res);
        scoreboard_entry_t e;
        e          = '0;
        e.fu       = ALU;
        e.op       = ADD;
        e.use_imm  = 1'b1;
        e.valid    = 1'b1;
        e.pc       = pc;
        e.trans_id = tid;
        e.result   = res;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkEntry(input string name, input scoreboard_entry_t act,
                              input scoreboard_entry_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output must match the head of the expected queue.
    always @(negedge clk_i) begin
        if (rst_n && !flush_i && valid_o && ack_i) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_output: got %h expected none", instr_o);
            end else begin
                checkEntry("scoreboard_entry", instr_o, expQ.pop_front());
            end
        end
        if (underflow_o) pulseCnt++;
    end

    task automatic applyStimulus(input scoreboard_entry_t e, input logic withMarker,
                                 input logic [31:0] mkRes);
        int waitCycles;
        waitCycles = 0;
        instr_i = e;
        valid_i = 1'b1;
        @(negedge clk_i);
        while (!ready_o && waitCycles < 50) begin
            @(negedge clk_i);
            waitCycles++;
        end
        if (!ready_o) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ready_timeout: got ready_o=0 expected 1 within 50 cycles");
        end else begin
            @(posedge clk_i);
            expQ.push_back(e);
            if (withMarker) expQ.push_back(expMarker(e.pc, e.trans_id, mkRes));
        end
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int waitCycles;
        waitCycles = 0;
        while ((expQ.size() != 0 || valid_o) && waitCycles < 50) begin
            @(negedge clk_i);
            waitCycles++;
        end
        checkOutput("drain_queue_empty", expQ.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int readyLow;
        int expPulses;
        scoreboard_entry_t retE;
        rst_n    = 1'b0;
        flush_i  = 1'b0;
        csr_en_i = 1'b1;
        valid_i  = 1'b0;
        instr_i  = '0;
        ack_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_n = 1'b1;
        @(negedge clk_i);
        checkOutput("reset_valid_o", valid_o, 0);
        checkOutput("reset_ready_o", ready_o, 1);
        checkEntry("reset_instr_o", instr_o, '0);
        checkOutput("reset_call_cnt", call_cnt_o, 0);
        checkOutput("reset_ret_cnt", ret_cnt_o, 0);
        checkOutput("reset_underflow", underflow_o, 0);
        @(posedge clk_i);
        #1;

        // ADD, ADD, JALR rd=1: call marker follows, one ready-low cycle
        applyStimulus(mkEntry(ALU, ADD, 5'd2, 5'd4, 32'h100, 3'd1), 1'b0, 0);
        applyStimulus(mkEntry(ALU, ADD, 5'd5, 5'd6, 32'h104, 3'd2), 1'b0, 0);
        applyStimulus(mkEntry(CTRL_FLOW, JALR, 5'd7, 5'd1, 32'h108, 3'd3), 1'b1, 32'd2);
        readyLow = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (!ready_o) readyLow++;
        end
        checkOutput("call_ready_low_cycles", readyLow, 1);
        drain();
        checkOutput("call_cnt_after_call", call_cnt_o, 1);

        // Return under back-pressure
        ack_i = 1'b0;
        retE = mkEntry(CTRL_FLOW, JALR, 5'd1, 5'd0, 32'h200, 3'd4);
        applyStimulus(retE, 1'b1, 32'd1);
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("bp_valid_o", valid_o, 1);
            checkEntry("bp_instr_o", instr_o, retE);
            checkOutput("bp_ready_o", ready_o, 0);
        end
        @(posedge clk_i);
        #1 ack_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("ret_marker_no_bubble", valid_o, 1);
        drain();
        checkOutput("ret_cnt_after_ret", ret_cnt_o, 1);

        // Disabled injection, then enable dropped while a marker is pending
        csr_en_i = 1'b0;
        applyStimulus(mkEntry(CTRL_FLOW, JAL, 5'd0, 5'd1, 32'h300, 3'd5), 1'b0, 0);
        drain();
        checkOutput("call_cnt_csr_off", call_cnt_o, 1);
        csr_en_i = 1'b1;
        ack_i    = 1'b0;
        applyStimulus(mkEntry(CTRL_FLOW, JALR, 5'd1, 5'd1, 32'h310, 3'd6), 1'b1, 32'd2);
        csr_en_i = 1'b0;
        @(posedge clk_i);
        #1 ack_i = 1'b1;
        drain();
        checkOutput("call_cnt_pending_kept", call_cnt_o, 2);

        // Flush right after a call is accepted, with a simultaneous input
        csr_en_i = 1'b1;
        ack_i    = 1'b0;
        applyStimulus(mkEntry(CTRL_FLOW, JAL, 5'd0, 5'd1, 32'h400, 3'd7), 1'b1, 32'd2);
        flush_i = 1'b1;
        valid_i = 1'b1;
        instr_i = mkEntry(ALU, ADD, 5'd2, 5'd9, 32'h404, 3'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        expQ.delete();
        @(negedge clk_i);
        checkOutput("flush_valid_o", valid_o, 0);
        checkOutput("flush_ready_o", ready_o, 1);
        ack_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checkOutput("flush_no_marker", valid_o, 0);
        checkOutput("flush_call_cnt_kept", call_cnt_o, 2);

        // Two returns: depth 1 -> 0, then a return at depth 0
        @(posedge clk_i);
        #1;
        applyStimulus(mkEntry(CTRL_FLOW, JALR, 5'd1, 5'd0, 32'h500, 3'd1), 1'b1, 32'd1);
        applyStimulus(mkEntry(CTRL_FLOW, JALR, 5'd1, 5'd0, 32'h504, 3'd2), 1'b1, 32'd1);
        drain();
        repeat (2) @(negedge clk_i);
        checkOutput("ret_cnt_final", ret_cnt_o, 3);
`ifdef CALL_DEPTH_TRACK_EN
        expPulses = 1;
`else
        expPulses = 0;
`endif
        checkOutput("underflow_pulses", pulseCnt, expPulses);
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
